cond_exec_stage: RTL and testbench

//   Execute-stage back end of the pipelined CPU, directly downstream of the ALU.

---
 rtl/cond_exec_stage.sv | 117 +++++++++++
 tb/tb_cond_exec_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_stage.sv
// Execute-stage back end: NZCV flags register, condition evaluation,
// side-effect gating and the EX/MEM pipeline register.
module cond_exec_stage #(
  parameter int N    = 32,
  parameter int RA_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [3:0]      cond_i,
  input  logic [1:0]      flag_write_i,
  input  logic            reg_write_i,
  input  logic            mem_write_i,
  input  logic            pc_src_i,
  input  logic [N-1:0]    alu_result_i,
  input  logic [3:0]      alu_flags_i,
  input  logic [N-1:0]    write_data_i,
  input  logic [RA_W-1:0] rd_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [3:0]      flags_o,
  output logic            cond_ex_o,
  output logic            pc_src_o,
  output logic            valid_o,
  output logic            reg_write_o,
  output logic            mem_write_o,
  output logic [N-1:0]    alu_result_o,
  output logic [N-1:0]    write_data_o,
  output logic [RA_W-1:0] rd_o
);

  logic [3:0]      r_flags;
  logic            r_valid;
  logic            r_reg_write;
  logic            r_mem_write;
  logic [N-1:0]    r_alu_result;
  logic [N-1:0]    r_write_data;
  logic [RA_W-1:0] r_rd;

  logic w_n, w_z, w_c, w_v;
  logic w_cond;
  logic w_go;
  logic w_sgn_eq;

  assign w_n      = r_flags[3];
  assign w_z      = r_flags[2];
  assign w_c      = r_flags[1];
  assign w_v      = r_flags[0];
  assign w_sgn_eq = (w_n == w_v);

  // Conditions see registered flags only; no bypass from alu_flags_i.
  always_comb begin
    w_cond = 1'b0;
    unique case (cond_i)
      4'h0: w_cond = w_z;
      4'h1: w_cond = ~w_z;
      4'h2: w_cond = w_c;
      4'h3: w_cond = ~w_c;
      4'h4: w_cond = w_n;
      4'h5: w_cond = ~w_n;
      4'h6: w_cond = w_v;
      4'h7: w_cond = ~w_v;
      4'h8: w_cond = w_c & ~w_z;
      4'h9: w_cond = ~w_c | w_z;
      4'hA: w_cond = w_sgn_eq;
      4'hB: w_cond = ~w_sgn_eq;
      4'hC: w_cond = ~w_z & w_sgn_eq;
      4'hD: w_cond = w_z | ~w_sgn_eq;
      4'hE: w_cond = 1'b1;
      4'hF: w_cond = 1'b0;
    endcase
  end

  assign w_go = valid_i & w_cond & ~flush_i & ~stall_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flags <= 4'b0000;
    end else if (w_go) begin
      if (flag_write_i[1]) r_flags[3:2] <= alu_flags_i[3:2];
      if (flag_write_i[0]) r_flags[1:0] <= alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
    end else if (flush_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!stall_i) begin
      r_valid      <= valid_i;
      r_reg_write  <= reg_write_i & valid_i & w_cond;
      r_mem_write  <= mem_write_i & valid_i & w_cond;
      r_alu_result <= alu_result_i;
      r_write_data <= write_data_i;
      r_rd         <= rd_i;
    end
  end

  assign flags_o      = r_flags;
  assign cond_ex_o    = w_cond;
  assign pc_src_o     = pc_src_i & valid_i & w_cond & ~flush_i;
  assign valid_o      = r_valid;
  assign reg_write_o  = r_reg_write;
  assign mem_write_o  = r_mem_write;
  assign alu_result_o = r_alu_result;
  assign write_data_o = r_write_data;
  assign rd_o         = r_rd;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed testbench for cond_exec_stage: flags, conditions,
// gating, stall, flush and async reset.
module tb_cond_exec_stage;

  localparam int N    = 32;
  localparam int RA_W = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            valid_i;
  logic [3:0]      cond_i;
  logic [1:0]      flag_write_i;
  logic            reg_write_i;
  logic            mem_write_i;
  logic            pc_src_i;
  logic [N-1:0]    alu_result_i;
  logic [3:0]      alu_flags_i;
  logic [N-1:0]    write_data_i;
  logic [RA_W-1:0] rd_i;
  logic            stall_i;
  logic            flush_i;
  logic [3:0]      flags_o;
  logic            cond_ex_o;
  logic            pc_src_o;
  logic            valid_o;
  logic            reg_write_o;
  logic            mem_write_o;
  logic [N-1:0]    alu_result_o;
  logic [N-1:0]    write_data_o;
  logic [RA_W-1:0] rd_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cond_exec_stage #(.N(N), .RA_W(RA_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(valid_i), .cond_i(cond_i),
    .flag_write_i(flag_write_i),
    .reg_write_i(reg_write_i),
    .mem_write_i(mem_write_i),
    .pc_src_i(pc_src_i),
    .alu_result_i(alu_result_i),
    .alu_flags_i(alu_flags_i),
    .write_data_i(write_data_i),
    .rd_i(rd_i), .stall_i(stall_i),
    .flush_i(flush_i), .flags_o(flags_o),
    .cond_ex_o(cond_ex_o),
    .pc_src_o(pc_src_o),
    .valid_o(valid_o),
    .reg_write_o(reg_write_o),
    .mem_write_o(mem_write_o),
    .alu_result_o(alu_result_o),
    .write_data_o(write_data_o),
    .rd_o(rd_o)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    valid_i      = 1'b0;
    cond_i       = 4'hE;
    flag_write_i = 2'b00;
    reg_write_i  = 1'b0;
    mem_write_i  = 1'b0;
    pc_src_i     = 1'b0;
    alu_result_i = '0;
    alu_flags_i  = 4'b0000;
    write_data_i = '0;
    rd_i         = '0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;

    // T1 reset
    #12;
    check("t1_flags", flags_o, 4'b0000);
    check("t1_valid", valid_o, 1'b0);
    check("t1_rw", reg_write_o, 1'b0);
    check("t1_res", alu_result_o, 32'h0);
    rst_ni = 1'b1;

    // T2 flag set then EQ/NE
    step();
    valid_i      = 1'b1;
    cond_i       = 4'hE;
    flag_write_i = 2'b11;
    alu_flags_i  = 4'b0100;
    step();
    check("t2_flags", flags_o, 4'b0100);
    check("t2_valid0", valid_o, 1'b1);
    flag_write_i = 2'b00;
    cond_i       = 4'h0;
    reg_write_i  = 1'b1;
    #1 check("t2_eq_cond", cond_ex_o, 1'b1);
    step();
    check("t2_eq_rw", reg_write_o, 1'b1);
    cond_i = 4'h1;
    #1 check("t2_ne_cond", cond_ex_o, 1'b0);
    step();
    check("t2_ne_valid", valid_o, 1'b1);
    check("t2_ne_rw", reg_write_o, 1'b0);

    // T3 partial flag write and signed conditions
    cond_i       = 4'hE;
    reg_write_i  = 1'b0;
    flag_write_i = 2'b11;
    alu_flags_i  = 4'b0000;
    step();
    check("t3_clr", flags_o, 4'b0000);
    flag_write_i = 2'b10;
    alu_flags_i  = 4'b1011;
    step();
    check("t3_flags", flags_o, 4'b1000);
    flag_write_i = 2'b00;
    cond_i = 4'hB; #1 check("t3_lt", cond_ex_o, 1'b1);
    cond_i = 4'hA; #1 check("t3_ge", cond_ex_o, 1'b0);
    cond_i = 4'hC; #1 check("t3_gt", cond_ex_o, 1'b0);
    cond_i = 4'hD; #1 check("t3_le", cond_ex_o, 1'b1);
    cond_i = 4'hF; #1 check("t3_nv", cond_ex_o, 1'b0);
    cond_i = 4'h4; #1 check("t3_mi", cond_ex_o, 1'b1);
    cond_i = 4'h9; #1 check("t3_ls", cond_ex_o, 1'b1);

    // T4 stall
    step();
    cond_i       = 4'hE;
    reg_write_i  = 1'b1;
    alu_result_i = 32'hAAAA_0001;
    write_data_i = 32'h1234_5678;
    rd_i         = 4'd3;
    step();
    check("t4_pre_res", alu_result_o, 32'hAAAA_0001);
    stall_i      = 1'b1;
    alu_result_i = 32'h5555_0002;
    write_data_i = 32'h8765_4321;
    rd_i         = 4'd7;
    flag_write_i = 2'b11;
    alu_flags_i  = 4'b1111;
    step();
    alu_result_i = 32'h5555_0003;
    step();
    check("t4_hold_res", alu_result_o, 32'hAAAA_0001);
    check("t4_hold_wd", write_data_o, 32'h1234_5678);
    check("t4_hold_rd", rd_o, 4'd3);
    check("t4_hold_flags", flags_o, 4'b1000);
    stall_i = 1'b0;
    step();
    check("t4_rel_res", alu_result_o, 32'h5555_0003);
    check("t4_rel_rd", rd_o, 4'd7);
    check("t4_rel_flags", flags_o, 4'b1111);

    // T5 flush, then flush with stall
    pc_src_i     = 1'b1;
    mem_write_i  = 1'b1;
    alu_flags_i  = 4'b0000;
    #1 check("t5_pc_on", pc_src_o, 1'b1);
    flush_i = 1'b1;
    #1 check("t5_pc_flush", pc_src_o, 1'b0);
    step();
    check("t5_valid", valid_o, 1'b0);
    check("t5_rw", reg_write_o, 1'b0);
    check("t5_mw", mem_write_o, 1'b0);
    check("t5_flags", flags_o, 4'b1111);
    flush_i      = 1'b0;
    flag_write_i = 2'b00;
    step();
    check("t5_reload_mw", mem_write_o, 1'b1);
    flush_i      = 1'b1;
    stall_i      = 1'b1;
    flag_write_i = 2'b11;
    #1 check("t5s_pc", pc_src_o, 1'b0);
    step();
    check("t5s_valid", valid_o, 1'b0);
    check("t5s_rw", reg_write_o, 1'b0);
    check("t5s_mw", mem_write_o, 1'b0);
    check("t5s_flags", flags_o, 4'b1111);

    // T6 async reset between edges
    flush_i      = 1'b0;
    stall_i      = 1'b0;
    flag_write_i = 2'b00;
    pc_src_i     = 1'b0;
    step();
    check("t6_pre_valid", valid_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    check("t6_flags", flags_o, 4'b0000);
    check("t6_valid", valid_o, 1'b0);
    check("t6_rw", reg_write_o, 1'b0);
    check("t6_mw", mem_write_o, 1'b0);
    check("t6_res", alu_result_o, 32'h0);
    check("t6_rd", rd_o, 4'd0);
    #1 rst_ni = 1'b1;
    mem_write_i  = 1'b0;
    alu_result_i = 32'hCAFE_0006;
    step();
    check("t6_post_valid", valid_o, 1'b1);
    check("t6_post_rw", reg_write_o, 1'b1);
    check("t6_post_res", alu_result_o, 32'hCAFE_0006);
    check("t6_post_flags", flags_o, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
